// File: rtl/peak_track.sv
// peak_track: per-range FFT peak tracker with three-point parabolic refinement.
// One magnitude frame arrives per Avalon-ST packet. The largest bin inside each
// programmable range is kept. After the frame, each peak is refined with a
// serial restoring divider, and one backpressured result per range is emitted.
module peak_track #(
    parameter int WIDTH  = 16,
    parameter int NPEAKS = 4,
    parameter int BWIDTH = 10,
    parameter int FRAC   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [$clog2(NPEAKS)-1:0] cfg_addr,
    input  logic [BWIDTH-1:0]         cfg_lo,
    input  logic [BWIDTH-1:0]         cfg_hi,
    output logic                      cfg_err,
    input  logic [WIDTH-1:0]          thresh,
    input  logic                      sink_valid,
    output logic                      sink_ready,
    input  logic                      sink_sop,
    input  logic                      sink_eop,
    input  logic [WIDTH-1:0]          sink_mag,
    output logic                      source_valid,
    input  logic                      source_ready,
    output logic                      source_sop,
    output logic                      source_eop,
    output logic                      source_found,
    output logic [BWIDTH-1:0]         source_bin,
    output logic [WIDTH-1:0]          source_mag,
    output logic [FRAC:0]             source_frac,
    output logic [BWIDTH+FRAC-1:0]    source_pos
);

    localparam int AW = $clog2(NPEAKS);
    localparam int SW = $clog2(FRAC + 2);
    localparam int DW = WIDTH + 3;
    localparam int PW = BWIDTH + FRAC;
    localparam logic [SW-1:0] LAST_STEP = SW'(FRAC + 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NPEAKS - 1);
    localparam logic [FRAC:0] HALF      = (FRAC + 1)'(1) << (FRAC - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CALC, OUT} state_t;

    state_t state, state_nxt;

    logic beat;
    logic xfer;

    // Range table
    logic [BWIDTH-1:0] lo_tab [NPEAKS];
    logic [BWIDTH-1:0] hi_tab [NPEAKS];

    // Sliding window and frame bookkeeping
    logic [WIDTH-1:0]  thr;
    logic [WIDTH-1:0]  p1;
    logic [WIDTH-1:0]  p2;
    logic [BWIDTH-1:0] cnt;

    // Per-range peak trackers
    logic [NPEAKS-1:0] found_vec;
    logic [BWIDTH-1:0] k_tab [NPEAKS];
    logic [WIDTH-1:0]  r_tab [NPEAKS];
    logic [WIDTH-1:0]  s_tab [NPEAKS];
    logic [WIDTH-1:0]  t_tab [NPEAKS];
    logic [NPEAKS-1:0] hit;

    // Refinement datapath
    logic [AW-1:0]     idx;
    logic [SW-1:0]     step;
    logic              num_neg;
    logic              skip;
    logic              ovf;
    logic [DW-1:0]     den_u;
    logic [DW-1:0]     rem;
    logic [FRAC:0]     dvd;
    logic [FRAC-1:0]   quo;

    logic [BWIDTH-1:0] k_sel;
    logic [WIDTH-1:0]  r_sel;
    logic [WIDTH-1:0]  s_sel;
    logic [WIDTH-1:0]  t_sel;
    logic [WIDTH-1:0]  num_abs_c;
    logic [DW-1:0]     den_c;
    logic              den_pos;
    logic [DW:0]       trial;
    logic              ge;
    logic [FRAC:0]     q_next;
    logic [FRAC:0]     q_mag;
    logic [FRAC:0]     frac_c;
    logic signed [PW:0] pos_c;
    logic [PW-1:0]     pos_out;

    assign sink_ready = (state == IDLE) || (state == ACCUM);
    assign beat       = sink_valid && sink_ready;
    assign xfer       = source_valid && source_ready;

    // State register: reset always returns to IDLE and aborts any frame or result sequence
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: a frame starts on sop, refinement runs per range, then results drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (beat && sink_sop) state_nxt = sink_eop ? CALC : ACCUM;
            ACCUM: if (beat && sink_eop) state_nxt = CALC;
            CALC:  if (step == LAST_STEP) state_nxt = OUT;
            OUT:   if (xfer) state_nxt = (idx == LAST_IDX) ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    // Range table writes are honoured only between frames; otherwise flag a rejection
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
            for (int i = 0; i < NPEAKS; i++) begin
                lo_tab[i] <= '0;
                hi_tab[i] <= '0;
            end
        end else begin
            cfg_err <= cfg_we && (state != IDLE);
            if (cfg_we && (state == IDLE)) begin
                lo_tab[cfg_addr] <= cfg_lo;
                hi_tab[cfg_addr] <= cfg_hi;
            end
        end
    end

    // Candidate test for center k=cnt; strict greater-than keeps the earliest bin on ties
    always_comb begin
        hit = '0;
        for (int i = 0; i < NPEAKS; i++) begin
            hit[i] = (cnt >= lo_tab[i]) && (cnt < hi_tab[i]) && (p1 >= thr) &&
                     (!found_vec[i] || (p1 > s_tab[i]));
        end
    end

    // Window shift and tracker update; the counter holds the index of the newest bin
    always_ff @(posedge clk) begin
        if (reset) begin
            thr       <= '0;
            cnt       <= '0;
            p1        <= '0;
            p2        <= '0;
            found_vec <= '0;
            for (int i = 0; i < NPEAKS; i++) begin
                k_tab[i] <= '0;
                r_tab[i] <= '0;
                s_tab[i] <= '0;
                t_tab[i] <= '0;
            end
        end else if (beat) begin
            if (sink_sop) begin
                thr       <= thresh;
                cnt       <= '0;
                p1        <= sink_mag;
                p2        <= '0;
                found_vec <= '0;
                for (int i = 0; i < NPEAKS; i++) begin
                    k_tab[i] <= '0;
                    r_tab[i] <= '0;
                    s_tab[i] <= '0;
                    t_tab[i] <= '0;
                end
            end else if ((state == ACCUM) && (cnt != '1)) begin
                for (int i = 0; i < NPEAKS; i++) begin
                    if (hit[i]) begin
                        found_vec[i] <= 1'b1;
                        k_tab[i]     <= cnt;
                        r_tab[i]     <= p2;
                        s_tab[i]     <= p1;
                        t_tab[i]     <= sink_mag;
                    end
                end
                cnt <= cnt + 1'b1;
                p2  <= p1;
                p1  <= sink_mag;
            end
        end
    end

    // Interpolation terms, one divider iteration, and final result formatting
    always_comb begin
        k_sel     = k_tab[idx];
        r_sel     = r_tab[idx];
        s_sel     = s_tab[idx];
        t_sel     = t_tab[idx];
        num_abs_c = (t_sel >= r_sel) ? (t_sel - r_sel) : (r_sel - t_sel);
        den_c     = {1'b0, s_sel, 2'b00} - {2'b00, r_sel, 1'b0} - {2'b00, t_sel, 1'b0};
        den_pos   = !den_c[DW-1] && (den_c != '0);
        trial     = {rem, dvd[FRAC]};
        ge        = trial >= {1'b0, den_u};
        q_next    = {quo, ge};
        q_mag     = (ovf || (q_next > HALF)) ? HALF : q_next;
        frac_c    = skip ? '0 : (num_neg ? -q_mag : q_mag);
        pos_c     = $signed({1'b0, k_sel, {FRAC{1'b0}}}) +
                    $signed({{(PW - FRAC){frac_c[FRAC]}}, frac_c});
        pos_out   = pos_c[PW] ? '0 : pos_c[PW-1:0];
    end

    // Serial restoring divider: a load cycle then FRAC+1 quotient bits, MSB first
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            step    <= '0;
            num_neg <= 1'b0;
            skip    <= 1'b1;
            ovf     <= 1'b0;
            den_u   <= '0;
            rem     <= '0;
            dvd     <= '0;
            quo     <= '0;
        end else begin
            case (state)
                CALC: begin
                    step <= step + 1'b1;
                    if (step == '0) begin
                        skip    <= !found_vec[idx] || !den_pos;
                        num_neg <= t_sel < r_sel;
                        den_u   <= den_c;
                        rem     <= DW'(num_abs_c >> 1);
                        ovf     <= DW'(num_abs_c >> 1) >= den_c;
                        dvd     <= {num_abs_c[0], {FRAC{1'b0}}};
                        quo     <= '0;
                    end else begin
                        rem <= ge ? DW'(trial - {1'b0, den_u}) : DW'(trial);
                        dvd <= {dvd[FRAC-1:0], 1'b0};
                        quo <= q_next[FRAC-1:0];
                    end
                end
                OUT: begin
                    step <= '0;
                    if (xfer && (idx != LAST_IDX)) idx <= idx + 1'b1;
                end
                default: begin
                    step <= '0;
                    idx  <= '0;
                end
            endcase
        end
    end

    // Result register: loaded when a range finishes refinement, held until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_found <= 1'b0;
            source_bin   <= '0;
            source_mag   <= '0;
            source_frac  <= '0;
            source_pos   <= '0;
        end else if ((state == CALC) && (step == LAST_STEP)) begin
            source_valid <= 1'b1;
            source_sop   <= (idx == '0);
            source_eop   <= (idx == LAST_IDX);
            source_found <= found_vec[idx];
            source_bin   <= found_vec[idx] ? k_sel : '0;
            source_mag   <= found_vec[idx] ? s_sel : '0;
            source_frac  <= found_vec[idx] ? frac_c : '0;
            source_pos   <= found_vec[idx] ? pos_out : '0;
        end else if (xfer) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peak_track.sv
// tb_peak_track: directed and randomized frames checked against a behavioural peak model.
module tb_peak_track;

    localparam int W = 16;
    localparam int N = 4;
    localparam int B = 10;
    localparam int F = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [B-1:0]  cfg_lo;
    logic [B-1:0]  cfg_hi;
    logic          cfg_err;
    logic [W-1:0]  thresh;
    logic          sink_valid;
    logic          sink_ready;
    logic          sink_sop;
    logic          sink_eop;
    logic [W-1:0]  sink_mag;
    logic          source_valid;
    logic          source_ready;
    logic          source_sop;
    logic          source_eop;
    logic          source_found;
    logic [B-1:0]  source_bin;
    logic [W-1:0]  source_mag;
    logic [F:0]    source_frac;
    logic [B+F-1:0] source_pos;

    peak_track #(.WIDTH(W), .NPEAKS(N), .BWIDTH(B), .FRAC(F)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_err(cfg_err),
        .thresh(thresh),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_mag(sink_mag),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop), .source_found(source_found),
        .source_bin(source_bin), .source_mag(source_mag), .source_frac(source_frac),
        .source_pos(source_pos)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fm [64];
    int lo_m [N];
    int hi_m [N];
    int thr_m;
    int ex_found [N];
    int ex_bin [N];
    int ex_mag [N];
    int ex_frac [N];
    int ex_pos [N];
    int ob_found [N];
    int ob_bin [N];
    int ob_frac [N];
    int ob_pos [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: best center per range, then parabolic offset clamped to +/-0.5
    task automatic computeModel(input int nbins);
        for (int i = 0; i < N; i++) begin
            int f = 0, bk = 0, bs = 0, r, t, num, den, q;
            for (int k = 0; k <= nbins - 2 && k < 1023; k++) begin
                if (k >= lo_m[i] && k < hi_m[i] && fm[k] >= thr_m && (f == 0 || fm[k] > bs)) begin
                    f = 1; bk = k; bs = fm[k];
                end
            end
            ex_found[i] = f;
            ex_bin[i]   = f ? bk : 0;
            ex_mag[i]   = f ? bs : 0;
            ex_frac[i]  = 0;
            ex_pos[i]   = 0;
            if (f) begin
                r   = (bk == 0) ? 0 : fm[bk-1];
                t   = fm[bk+1];
                num = t - r;
                den = 2 * (2 * bs - r - t);
                if (den > 0) begin
                    q = ((num < 0 ? -num : num) * 256) / den;
                    if (q > 128) q = 128;
                    ex_frac[i] = (num < 0) ? -q : q;
                end
                ex_pos[i] = bk * 256 + ex_frac[i];
                if (ex_pos[i] < 0) ex_pos[i] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input int nbins, input int gaps, input int cfg_at);
        for (int b = 0; b < nbins; b++) begin
            if (gaps != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    sink_valid = 1'b0;
                    sink_mag   = W'($urandom);
                    tick();
                end
            end
            sink_valid = 1'b1;
            sink_sop   = (b == 0);
            sink_eop   = (b == nbins - 1);
            sink_mag   = W'(fm[b]);
            if (b == cfg_at) begin
                cfg_we = 1'b1; cfg_addr = 2'd0; cfg_lo = B'(15); cfg_hi = B'(16);
            end
            tick();
            if (b == cfg_at) begin
                cfg_we = 1'b0;
                checkOutput("cfg_err_pulse", cfg_err, 1);
            end
        end
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        if (cfg_at >= 0) checkOutput("cfg_err_clear", cfg_err, 0);
    endtask

    task automatic collectResult(input int i, input int hold, input int rnd);
        int waitc = 0;
        logic [55:0] snap;
        while (source_valid !== 1'b1 && waitc < 300) begin
            tick();
            waitc++;
        end
        checkOutput("valid_timeout", source_valid, 1);
        if (source_valid !== 1'b1) return;
        if (hold > 0) begin
            snap = {source_sop, source_eop, source_found, source_bin, source_mag, source_frac, source_pos};
            for (int h = 0; h < hold; h++) begin
                tick();
                checkOutput("hold_valid", source_valid, 1);
                checkOutput("hold_stable",
                    ({source_sop, source_eop, source_found, source_bin, source_mag,
                      source_frac, source_pos} == snap), 1);
                checkOutput("hold_sink_ready", sink_ready, 0);
            end
        end
        if (rnd != 0) repeat ($urandom_range(0, 3)) tick();
        checkOutput("sop", source_sop, (i == 0));
        checkOutput("eop", source_eop, (i == N - 1));
        checkOutput("found", source_found, ex_found[i]);
        checkOutput("bin", source_bin, ex_bin[i]);
        checkOutput("mag", source_mag, ex_mag[i]);
        checkOutput("frac", $signed(source_frac), ex_frac[i]);
        checkOutput("pos", source_pos, ex_pos[i]);
        ob_found[i] = source_found;
        ob_bin[i]   = source_bin;
        ob_frac[i]  = $signed(source_frac);
        ob_pos[i]   = source_pos;
        source_ready = 1'b1;
        tick();
        source_ready = 1'b0;
    endtask

    task automatic runFrame(input int nbins, input int gaps, input int hold_idx,
                            input int cfg_at, input int rnd);
        thresh = W'(thr_m);
        computeModel(nbins);
        applyStimulus(nbins, gaps, cfg_at);
        for (int i = 0; i < N; i++) collectResult(i, (i == hold_idx) ? 5 : 0, rnd);
    endtask

    task automatic cfgWrite(input int a, input int lo, input int hi);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_lo = B'(lo); cfg_hi = B'(hi);
        tick();
        cfg_we = 1'b0;
        checkOutput("cfg_err_idle", cfg_err, 0);
        lo_m[a] = lo;
        hi_m[a] = hi;
    endtask

    task automatic clearFrame();
        for (int b = 0; b < 64; b++) fm[b] = 0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waitc;
        int sawv;
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_lo = '0; cfg_hi = '0;
        thresh = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        sink_mag = '0; source_ready = 1'b0;
        for (int i = 0; i < N; i++) begin lo_m[i] = 0; hi_m[i] = 0; end
        repeat (3) tick();
        checkOutput("rst_sink_ready", sink_ready, 1);
        checkOutput("rst_valid", source_valid, 0);
        checkOutput("rst_sop", source_sop, 0);
        checkOutput("rst_eop", source_eop, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_found", source_found, 0);
        checkOutput("rst_bin", source_bin, 0);
        checkOutput("rst_mag", source_mag, 0);
        checkOutput("rst_frac", source_frac, 0);
        checkOutput("rst_pos", source_pos, 0);
        reset = 1'b0;
        tick();

        // Beats without sop while idle must be dropped
        sink_valid = 1'b1; sink_mag = W'(60000);
        repeat (3) tick();
        sink_valid = 1'b0;

        $display("[TB] basic peak frame");
        cfgWrite(0, 10, 20);
        thr_m = 50;
        clearFrame();
        fm[13] = 100; fm[14] = 200; fm[15] = 150;
        runFrame(32, 0, -1, -1, 0);
        checkOutput("tp_bin", ob_bin[0], 14);
        checkOutput("tp_frac_pos", ob_frac[0], 42);
        checkOutput("tp_pos_pos", ob_pos[0], 3626);

        fm[13] = 150; fm[15] = 100;
        runFrame(32, 0, -1, -1, 0);
        checkOutput("tp_frac_neg", ob_frac[0], -42);
        checkOutput("tp_pos_neg", ob_pos[0], 3542);

        fm[13] = 100; fm[15] = 100;
        runFrame(32, 0, -1, -1, 0);
        checkOutput("tp_frac_zero", ob_frac[0], 0);
        checkOutput("tp_pos_zero", ob_pos[0], 3584);

        $display("[TB] threshold and tie");
        clearFrame();
        fm[14] = 40;
        runFrame(32, 0, -1, -1, 0);
        checkOutput("below_thresh", ob_found[0], 0);
        clearFrame();
        fm[12] = 200; fm[16] = 200;
        runFrame(32, 0, -1, -1, 0);
        checkOutput("tie_bin", ob_bin[0], 12);

        $display("[TB] backpressure and rejected config");
        clearFrame();
        fm[13] = 100; fm[14] = 200; fm[15] = 150;
        runFrame(32, 0, 1, -1, 0);
        runFrame(32, 1, -1, 5, 0);
        checkOutput("cfg_unchanged_bin", ob_bin[0], 14);

        $display("[TB] reset during output");
        thresh = W'(thr_m);
        applyStimulus(32, 0, -1);
        waitc = 0;
        while (source_valid !== 1'b1 && waitc < 300) begin tick(); waitc++; end
        checkOutput("pre_reset_valid", source_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_valid", source_valid, 0);
        checkOutput("mid_rst_sink_ready", sink_ready, 1);
        sawv = 0;
        repeat (20) begin tick(); if (source_valid === 1'b1) sawv = 1; end
        checkOutput("no_partial", sawv, 0);
        for (int i = 0; i < N; i++) begin lo_m[i] = 0; hi_m[i] = 0; end
        runFrame(32, 0, -1, -1, 0);
        checkOutput("table_cleared", ob_found[0], 0);

        $display("[TB] edge bins");
        cfgWrite(0, 0, 8);
        clearFrame();
        fm[0] = 200; fm[1] = 100; fm[7] = 500;
        runFrame(8, 0, -1, -1, 0);
        checkOutput("bin0_bin", ob_bin[0], 0);
        checkOutput("bin0_frac", ob_frac[0], 42);
        checkOutput("bin0_pos", ob_pos[0], 42);
        clearFrame();
        fm[0] = 1000;
        runFrame(1, 0, -1, -1, 0);
        checkOutput("one_bin_frame", ob_found[0], 0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) cfgWrite(i, $urandom_range(0, 40), $urandom_range(0, 48));
            thr_m = $urandom_range(0, 50000);
            clearFrame();
            for (int b = 0; b < 64; b++) fm[b] = $urandom_range(0, 65535);
            runFrame($urandom_range(2, 48), 1, $urandom_range(0, 7), -1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
